// File: rtl/mips_ex_pkg.sv
// Shared constants and types for the MIPS EX-stage control: ALU op codes,
// opcode/funct encodings, the mult/div op kinds and the iterative-unit states.
package mips_ex_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_PASS = 5'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } md_kind_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

  function automatic logic md_is_arith(input md_kind_t k);
    return (k == MD_MULT) || (k == MD_MULTU) || (k == MD_DIV) || (k == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step
// per cycle on magnitudes, with the sign fix-up applied combinationally on the result.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             start,
  input  logic             step,
  input  logic             div_op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             div_q, neg_q, rneg_q, zero_q;
  logic [WIDTH-1:0] opnd_q, raw_a_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH:0]   sum, shl, diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (2*WIDTH)'(-v) : v;
  endfunction

  // Operands are stored as magnitudes; the remembered signs drive the fix-up.
  always_ff @(posedge clk) begin
    if (start) begin
      div_q    <= div_op;
      neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q   <= signed_op & a[WIDTH-1];
      zero_q   <= (b == '0);
      raw_a_q  <= a;
      opnd_q   <= mag(a == a ? b : b, signed_op);
      acc_hi_q <= '0;
      acc_lo_q <= mag(a, signed_op);
    end else if (step) begin
      acc_hi_q <= hi_step;
      acc_lo_q <= lo_step;
    end
  end

  // A non-negative trial difference always fits in WIDTH bits because the
  // running remainder stays below the divisor, so bit WIDTH is a pure borrow.
  always_comb begin
    sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    shl  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff = shl - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hi_step = diff[WIDTH-1:0];
        lo_step = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shl[WIDTH-1:0];
        lo_step = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg2_if({acc_hi_q, acc_lo_q}, neg_q);
    if (!div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (zero_q) begin
      res_hi = raw_a_q;
      res_lo = '1;
    end else begin
      res_hi = neg_if(acc_hi_q, rneg_q);
      res_lo = neg_if(acc_lo_q, neg_q);
    end
  end

endmodule

// File: rtl/ex_ctrl_md.sv
// EX-stage control: ALU op/sign decode plus sequencing of the iterative
// mult/div unit into the architectural HI/LO registers, with hazard stall.
module ex_ctrl_md
  import mips_ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MD_EN = 1,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [4:0]       alu_ctrl,
  output logic             sign,
  output logic             md_stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam bit MDE = (MD_EN != 0);

  md_kind_t         md_kind;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hi_q, lo_q, hi_nx, lo_nx, res_hi, res_lo;
  logic             hi_we, lo_we, start, step, live;

  always_comb begin
    alu_ctrl = ALU_ADD;
    sign     = 1'b0;
    md_kind  = MD_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  sign = 1'b1;
          F_SUB:  begin alu_ctrl = ALU_SUB; sign = 1'b1; end
          F_SUBU: alu_ctrl = ALU_SUB;
          F_AND:  begin alu_ctrl = ALU_AND; sign = 1'b1; end
          F_OR:   begin alu_ctrl = ALU_OR;  sign = 1'b1; end
          F_XOR:  begin alu_ctrl = ALU_XOR; sign = 1'b1; end
          F_NOR:  begin alu_ctrl = ALU_NOR; sign = 1'b1; end
          F_SLL:  alu_ctrl = ALU_SLL;
          F_SRL:  alu_ctrl = ALU_SRL;
          F_SRA:  begin alu_ctrl = ALU_SRA; sign = 1'b1; end
          F_SLT:  begin alu_ctrl = ALU_SLT; sign = 1'b1; end
          F_SLTU: alu_ctrl = ALU_SLT;
          F_JR, F_JALR: sign = 1'b1;
          F_MULT:  if (MDE) md_kind = MD_MULT;
          F_MULTU: if (MDE) md_kind = MD_MULTU;
          F_DIV:   if (MDE) md_kind = MD_DIV;
          F_DIVU:  if (MDE) md_kind = MD_DIVU;
          F_MFHI:  if (MDE) md_kind = MD_MFHI;
          F_MFLO:  if (MDE) md_kind = MD_MFLO;
          F_MTHI:  if (MDE) md_kind = MD_MTHI;
          F_MTLO:  if (MDE) md_kind = MD_MTLO;
          default: ;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: sign = 1'b1;
      OP_ANDI:  begin alu_ctrl = ALU_AND; sign = 1'b1; end
      OP_SLTI:  begin alu_ctrl = ALU_SLT; sign = 1'b1; end
      OP_SLTIU: alu_ctrl = ALU_SLT;
      OP_BEQ:   begin alu_ctrl = ALU_SUB; sign = 1'b1; end
      OP_J, OP_JAL: begin alu_ctrl = ALU_PASS; sign = 1'b1; end
      default: ;
    endcase
  end

  assign live     = in_valid & ~flush;
  assign md_busy  = (state != ST_IDLE);
  assign md_stall = live & md_busy & (md_kind != MD_NONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (hi_we) hi_q <= hi_nx;
      if (lo_we) lo_q <= lo_nx;
    end
  end

  // A flush in CALC or FIX abandons the operation without touching HI/LO.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    step     = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_nx    = res_hi;
    lo_nx    = res_lo;
    md_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (live && md_is_arith(md_kind)) begin
          start    = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_CALC;
        end else if (live && md_kind == MD_MTHI) begin
          hi_we = 1'b1;
          hi_nx = rs_val;
        end else if (live && md_kind == MD_MTLO) begin
          lo_we = 1'b1;
          lo_nx = rs_val;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_nx = ST_FIX;
          else                          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      ST_FIX: begin
        state_nx = ST_IDLE;
        if (!flush) begin
          md_done = 1'b1;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .start     (start),
    .step      (step),
    .div_op    ((md_kind == MD_DIV) || (md_kind == MD_DIVU)),
    .signed_op ((md_kind == MD_MULT) || (md_kind == MD_DIV)),
    .a         (rs_val),
    .b         (rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  assign hi = MDE ? hi_q : '0;
  assign lo = MDE ? lo_q : '0;

endmodule

// File: tb/tb_ex_ctrl_md.sv
// Bench for ex_ctrl_md at WIDTH=32: decode table, mult/div result table with
// a HI/LO scoreboard, and hand sequences for stall, flush and mid-op reset.
module tb_ex_ctrl_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, flush;
  logic [5:0]   opcode, funct;
  logic [W-1:0] rs_val, rt_val;
  logic [4:0]   alu_ctrl;
  logic         sign, md_stall, md_busy, md_done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  ex_ctrl_md #(.WIDTH(W), .MD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .alu_ctrl(alu_ctrl), .sign(sign), .md_stall(md_stall), .md_busy(md_busy),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] alu;
    logic       sg;
  } dec_vec_t;

  typedef struct {
    logic [5:0]   fn;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } md_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; opcode = 6'h00; funct = 6'h00;
    rs_val = '0; rt_val = '0;
  endtask

  task automatic pop_check(input string name);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(name, {hi, lo}, e);
    end
  endtask

  // Issue one mult/div, expect md_done exactly W cycles after the accept edge.
  task automatic run_md(input string name, input logic [5:0] fn,
                        input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    in_valid = 1'b1; opcode = 6'h00; funct = fn; rs_val = rs; rt_val = rt;
    #1;
    check({name, "_nostall_idle"}, md_stall, 0);
    sb_q.push_back({ehi, elo});
    tick();
    idle_inputs();
    n = 0;
    while (!md_done && n < 40) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, W);
    tick();
    pop_check({name, "_hilo"});
    check({name, "_done_pulse"}, {md_done, md_busy}, 2'b00);
  endtask

  dec_vec_t dec_tbl[9];
  md_vec_t  md_tbl[9];

  initial begin
    int n;
    logic last_done, seen_done;

    dec_tbl[0] = '{6'h00, 6'h21, 5'd0,  1'b0};
    dec_tbl[1] = '{6'h00, 6'h03, 5'd8,  1'b1};
    dec_tbl[2] = '{6'h0b, 6'h00, 5'd9,  1'b0};
    dec_tbl[3] = '{6'h0f, 6'h00, 5'd0,  1'b0};
    dec_tbl[4] = '{6'h03, 6'h00, 5'd10, 1'b1};
    dec_tbl[5] = '{6'h3f, 6'h00, 5'd0,  1'b0};
    dec_tbl[6] = '{6'h00, 6'h22, 5'd1,  1'b1};
    dec_tbl[7] = '{6'h04, 6'h00, 5'd1,  1'b1};
    dec_tbl[8] = '{6'h00, 6'h27, 5'd5,  1'b1};

    md_tbl[0] = '{6'h18, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    md_tbl[1] = '{6'h19, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
    md_tbl[2] = '{6'h1b, 32'd100,      32'd7,        32'd2,        32'd14};
    md_tbl[3] = '{6'h1a, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    md_tbl[4] = '{6'h1a, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    md_tbl[5] = '{6'h1a, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    md_tbl[6] = '{6'h1a, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    md_tbl[7] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    md_tbl[8] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check("reset_outs", {hi, lo, md_busy, md_done, md_stall}, '0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      opcode = dec_tbl[i].op; funct = dec_tbl[i].fn;
      #1;
      check($sformatf("dec%0d", i), {alu_ctrl, sign}, {dec_tbl[i].alu, dec_tbl[i].sg});
    end
    idle_inputs();
    tick();

    for (int i = 0; i < 9; i++)
      run_md($sformatf("md%0d", i), md_tbl[i].fn, md_tbl[i].rs, md_tbl[i].rt,
             md_tbl[i].ehi, md_tbl[i].elo);

    // mfhi waits on a busy unit; an ALU op during CALC does not.
    in_valid = 1'b1; funct = 6'h18; rs_val = 32'hFFFFFFFD; rt_val = 32'd5;
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    tick();
    funct = 6'h20;
    #1;
    check("add_in_calc_nostall", md_stall, 0);
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; funct = 6'h10;
    #1;
    check("mfhi_stall_start", md_stall, 1);
    n = 0; last_done = 1'b0; seen_done = 1'b0;
    while (md_stall && n < 60) begin
      last_done = md_done;
      if (md_done) seen_done = 1'b1;
      tick();
      n++;
    end
    check("mfhi_stall_released", md_stall, 0);
    check("mfhi_done_seen", seen_done, 1);
    check("mfhi_release_after_fix", last_done, 1);
    pop_check("mfhi_hilo");
    idle_inputs();
    tick();

    // mthi/mtlo then flush mid-CALC: HI/LO keep the moved values.
    in_valid = 1'b1; funct = 6'h11; rs_val = 32'h00001234;
    tick();
    funct = 6'h13; rs_val = 32'h00005678;
    tick();
    check("mthi_mtlo", {hi, lo}, {32'h00001234, 32'h00005678});
    funct = 6'h18; rs_val = 32'd9; rt_val = 32'd9; flush = 1'b1;
    tick();
    check("flush_in_idle_not_accepted", md_busy, 0);
    flush = 1'b0;
    tick();
    idle_inputs();
    check("accept_busy", md_busy, 1);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_drop", md_busy, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) seen_done = 1'b1;
      tick();
    end
    check("flush_no_done", seen_done, 0);
    check("flush_hilo_kept", {hi, lo}, {32'h00001234, 32'h00005678});

    // Reset in the middle of CALC discards the operation and clears HI/LO.
    in_valid = 1'b1; funct = 6'h18; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    idle_inputs();
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    check("midop_reset", {hi, lo, md_busy, md_done, md_stall}, '0);
    reset = 1'b1;
    tick();
    run_md("post_reset_mult", 6'h18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
